// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, runs the single-outstanding instruction memory
// read handshake and buffers returned words with their PCs for the IQ.
//
// Ports:
//   clk, reset_n        clock / async active-low reset
//   instr_read          memory read request, held until instr_mem_resp
//   instr_mem_address   request address, stable while instr_read=1
//   instr_mem_resp      one-cycle response strobe, instr_mem_rdata valid
//   instr_mem_rdata     returned instruction word
//   iq_valid            fetch buffer head valid
//   iq_instr, iq_pc     head instruction word and its PC (0 when empty)
//   iq_deq              IQ consumes head this cycle (ignored when empty)
//   redirect            flush buffer and in-flight fetch, restart at redirect_pc
//   redirect_pc         new fetch PC
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0060,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_read,
  output logic [31:0] instr_mem_address,
  input  logic        instr_mem_resp,
  input  logic [31:0] instr_mem_rdata,
  output logic        iq_valid,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  input  logic        iq_deq,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t        state, state_n;
  logic [31:0]   pc, pc_n;
  logic [31:0]   req_addr, req_addr_n;
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_deq;
  logic          deq_ok;
  logic          push, pop, flush;

  assign deq_ok  = iq_deq && (count != '0);
  // occupancy once this cycle's dequeue has taken effect
  assign cnt_deq = count - CW'(deq_ok);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    push       = 1'b0;
    flush      = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          pc_n  = redirect_pc;
          flush = 1'b1;
        end else if (cnt_deq < DEPTH_C) begin
          req_addr_n = pc;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          flush   = 1'b1;
          // a pending response still has to be absorbed
          state_n = instr_mem_resp ? IDLE : DISCARD;
        end else if (instr_mem_resp) begin
          push = 1'b1;
          pc_n = pc + 32'd4;
          if (cnt_deq + CW'(1) < DEPTH_C) begin
            req_addr_n = pc + 32'd4;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          pc_n  = redirect_pc;
          flush = 1'b1;
        end
        if (instr_mem_resp) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop = deq_ok && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[tail] <= instr_mem_rdata;
      buf_pc[tail]    <= req_addr;
    end
  end

  assign instr_read        = (state == REQ) || (state == DISCARD);
  assign instr_mem_address = req_addr;
  assign iq_valid          = (count != '0);
  assign iq_instr          = iq_valid ? buf_instr[head] : '0;
  assign iq_pc             = iq_valid ? buf_pc[head] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch against a queue-based
// reference model of the fetch buffer and the single outstanding request.
module tb_instr_fetch;

  localparam int D = 4;
  localparam logic [31:0] RPC = 32'h4000_0060;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        iq_valid;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        iq_deq;
  logic        redirect;
  logic [31:0] redirect_pc;

  instr_fetch #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .iq_valid          (iq_valid),
    .iq_instr          (iq_instr),
    .iq_pc             (iq_pc),
    .iq_deq            (iq_deq),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: queue of {pc, instr}, fetch PC, outstanding request
  bit [63:0] m_q[$];
  bit [31:0] m_pc;
  bit [31:0] m_req;
  bit        m_out;
  bit        m_stale;

  // memory model
  int wait_cnt = 0;
  int mem_lat  = 1;
  bit mem_rand = 0;

  function automatic void model_reset();
    m_q.delete();
    m_pc    = RPC;
    m_req   = '0;
    m_out   = 1'b0;
    m_stale = 1'b0;
  endfunction

  function automatic bit [97:0] exp_vec();
    bit [31:0] p, w;
    p = '0;
    w = '0;
    if (m_q.size() != 0) begin
      p = m_q[0][63:32];
      w = m_q[0][31:0];
    end
    return {m_out, m_req, m_q.size() != 0, p, w};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {instr_read, instr_mem_address, iq_valid, iq_pc, iq_instr};
  endfunction

  task automatic drive(input bit deq, input bit rd, input logic [31:0] rpc);
    iq_deq      = deq;
    redirect    = rd;
    redirect_pc = rpc;
    if (mem_rand)
      instr_mem_resp = instr_read && ($urandom_range(0, 2) == 0);
    else
      instr_mem_resp = instr_read && (wait_cnt >= mem_lat);
    instr_mem_rdata = $urandom;
    #1;
  endtask

  // advance one clock and apply the same cycle to the model
  task automatic tick();
    bit rd_seen;
    bit deq;
    rd_seen = instr_read;
    @(posedge clk);
    deq = iq_deq && (m_q.size() != 0);
    if (!reset_n) begin
      model_reset();
    end else if (redirect) begin
      m_pc = redirect_pc;
      m_q.delete();
      if (m_out) begin
        if (instr_mem_resp) begin
          m_out   = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else if (!m_out) begin
      if (deq) void'(m_q.pop_front());
      if (m_q.size() < D) begin
        m_out = 1'b1;
        m_req = m_pc;
      end
    end else if (m_stale) begin
      if (deq) void'(m_q.pop_front());
      if (instr_mem_resp) begin
        m_out   = 1'b0;
        m_stale = 1'b0;
      end
    end else if (instr_mem_resp) begin
      if (m_q.size() >= D) begin
        n_err++;
        $display("FAIL overflow push into full buffer size=%0d max=%0d",
                 m_q.size(), D);
      end
      if (deq) void'(m_q.pop_front());
      m_q.push_back({m_req, instr_mem_rdata});
      m_pc = m_pc + 32'd4;
      if (m_q.size() < D) m_req = m_pc;
      else m_out = 1'b0;
    end else if (deq) begin
      void'(m_q.pop_front());
    end
    if (!reset_n) wait_cnt = 0;
    else if (rd_seen) wait_cnt = instr_mem_resp ? 0 : wait_cnt + 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    iq_deq         = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_mem_resp = 1'b0;
    instr_mem_rdata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (dut_vec() !== 98'd0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    reset_n = 1'b1;
    drive(0, 0, 0);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_fill();
    mem_lat  = 1;
    mem_rand = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL fill c%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      tick();
    end
    n_vec++;
    if (iq_pc !== 32'h4000_0060 || instr_read !== 1'b0 || iq_valid !== 1'b1) begin
      n_err++;
      $display("FAIL fill_full pc=%h rd=%b v=%b exp pc=40000060 rd=0 v=1",
               iq_pc, instr_read, iq_valid);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL drain c%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_latency();
    mem_lat = 3;
    for (int i = 0; i < 24; i++) begin
      drive(i[0], 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL latency c%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_redirect_req();
    int k;
    mem_lat = 3;
    k = 0;
    while (!(m_out && !m_stale && wait_cnt == 1) && k < 40) begin
      drive(1, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL redir_req_setup got=%h exp=%h", dut_vec(), exp_vec());
      end
      tick();
      k++;
    end
    n_vec++;
    if (k >= 40) begin
      n_err++;
      $display("FAIL redir_req_timeout waited=%0d limit=40", k);
    end
    drive(0, 1, 32'h4000_0100);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL redir_req_edge got=%h exp=%h", dut_vec(), exp_vec());
    end
    tick();
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL redir_req c%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      if (i < 3) begin
        n_vec++;
        if (iq_valid !== 1'b0) begin
          n_err++;
          $display("FAIL redir_req_empty c%0d got=%b exp=0", i, iq_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect_resp();
    int k;
    mem_lat = 1;
    drive(0, 1, 32'h4000_0180);
    tick();
    k = 0;
    while (!(m_out && !m_stale && m_q.size() == 2 && wait_cnt >= mem_lat)
           && k < 40) begin
      drive(0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL redir_resp_setup got=%h exp=%h", dut_vec(), exp_vec());
      end
      tick();
      k++;
    end
    n_vec++;
    if (k >= 40) begin
      n_err++;
      $display("FAIL redir_resp_timeout waited=%0d limit=40", k);
    end
    drive(1, 1, 32'h4000_0200);
    tick();
    drive(0, 0, 0);
    n_vec++;
    if (iq_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL redir_resp_flush got=%h exp=%h", dut_vec(), exp_vec());
    end
    tick();
    drive(0, 0, 0);
    n_vec++;
    if (instr_read !== 1'b1 || instr_mem_address !== 32'h4000_0200) begin
      n_err++;
      $display("FAIL redir_resp_addr rd=%b addr=%h exp rd=1 addr=40000200",
               instr_read, instr_mem_address);
    end
    tick();
  endtask

  task automatic test_full_wrap();
    mem_lat = 1;
    for (int i = 0; i < 40; i++) begin
      drive((i >= 12) && ($urandom_range(0, 1) == 1), 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL full_wrap c%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    mem_rand = 1;
    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'd3);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, rpc);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random c%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
      tick();
    end
    mem_rand = 0;
  endtask

  task automatic test_reset_mid();
    int k;
    mem_lat = 5;
    k = 0;
    while (!(m_out && !m_stale && wait_cnt == 2) && k < 60) begin
      drive(1, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rst_mid_setup got=%h exp=%h", dut_vec(), exp_vec());
      end
      tick();
      k++;
    end
    n_vec++;
    if (k >= 60) begin
      n_err++;
      $display("FAIL rst_mid_timeout waited=%0d limit=60", k);
    end
    reset_n        = 1'b0;
    iq_deq         = 1'b0;
    redirect       = 1'b0;
    instr_mem_resp = 1'b0;
    #1;
    n_vec++;
    if (dut_vec() !== 98'd0) begin
      n_err++;
      $display("FAIL rst_mid_clear got=%h exp=0", dut_vec());
    end
    model_reset();
    tick();
    reset_n         = 1'b1;
    instr_mem_resp  = 1'b1;
    instr_mem_rdata = $urandom;
    #1;
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL rst_mid_stray got=%h exp=%h", dut_vec(), exp_vec());
    end
    tick();
    drive(0, 0, 0);
    n_vec++;
    if (instr_read !== 1'b1 || instr_mem_address !== 32'h4000_0060 ||
        iq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_first rd=%b addr=%h v=%b exp rd=1 addr=40000060 v=0",
               instr_read, instr_mem_address, iq_valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_latency();
    test_redirect_req();
    test_redirect_resp();
    test_full_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
